// File: rtl/dataflow_engine_if.sv
// Command channel of dataflow_engine: valid/ready command fields plus the
// external read-data strobe that commands with src=data_in wait on.
// master: sequencer side (drives commands and data), slave: engine side.
interface dataflow_engine_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_src;
  logic [RW-1:0]     cmd_sidx;
  logic              cmd_wreg;
  logic [RW-1:0]     cmd_didx;
  logic [3:0]        cmd_dest;
  logic [2:0]        cmd_pc;
  logic [2:0]        cmd_alu;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;

  modport master (
    output cmd_valid, cmd_src, cmd_sidx, cmd_wreg, cmd_didx, cmd_dest,
           cmd_pc, cmd_alu, data_in, data_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_sidx, cmd_wreg, cmd_didx, cmd_dest,
           cmd_pc, cmd_alu, data_in, data_valid,
    output cmd_ready
  );
endinterface

// File: rtl/dataflow_engine.sv
// Purpose: width-parametrised micro-op datapath (regs, PC, ABL/ABH/DOR, ALU+PSR) fed by a command FIFO.
// Latency: command accepted at edge t executes at edge t+2; one command per cycle sustained.
// Backpressure: cmd_ready = !full (no pass-through, 0 in reset); head stalls while it needs data_in and data_valid=0.
// Ports: clk, nrst (sync active-low), cmd_if (slave: commands + data_in/data_valid),
//        dor/abl/abh (DATA_W), pc {PCH,PCL}, psr {N,V,Z,C}, busy (FIFO non-empty).
module dataflow_engine #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  dataflow_engine_if.slave      cmd_if,
  output logic [DATA_W-1:0]     dor,
  output logic [DATA_W-1:0]     abl,
  output logic [DATA_W-1:0]     abh,
  output logic [2*DATA_W-1:0]   pc,
  output logic [3:0]            psr,
  output logic                  busy
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int MSB = DATA_W - 1;
  localparam logic [AW:0]         PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] PC_ONE  = {{(2*DATA_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]    src;
    logic [RW-1:0] sidx;
    logic          wreg;
    logic [RW-1:0] didx;
    logic [3:0]    dest;
    logic [2:0]    pc;
    logic [2:0]    alu;
  } cmd_t;

  // ---------------- command FIFO ----------------
  cmd_t        fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // wr_ptr delayed one cycle: an entry becomes eligible to execute only in the
  // cycle after it was written, giving the fixed two-edge accept-to-execute latency.
  logic [AW:0] vis_ptr;
  logic        full, empty, head_vld, push, stall, exec;
  cmd_t        cmd_in, head;

  assign cmd_in = '{src:  cmd_if.cmd_src,  sidx: cmd_if.cmd_sidx,
                    wreg: cmd_if.cmd_wreg, didx: cmd_if.cmd_didx,
                    dest: cmd_if.cmd_dest, pc:   cmd_if.cmd_pc,
                    alu:  cmd_if.cmd_alu};

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head_vld = (vis_ptr != rd_ptr);
  assign cmd_if.cmd_ready = nrst && !full;
  assign push     = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign head     = fifo_mem[rd_ptr[AW-1:0]];
  assign stall    = (head.src == 3'd1) && !cmd_if.data_valid;
  assign exec     = head_vld && !stall;
  assign busy     = !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_in;
  end

  // ---------------- datapath ----------------
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] bus;

  always_comb begin
    bus = '0;
    case (head.src)
      3'd0: bus = '0;
      3'd1: bus = cmd_if.data_in;
      3'd2: bus = regs[head.sidx];
      3'd3: bus = alu_r;
      3'd4: bus = pc[DATA_W-1:0];
      3'd5: bus = pc[2*DATA_W-1:DATA_W];
      3'd6: bus = {{(DATA_W-4){1'b0}}, psr};
      default: bus = '1;
    endcase
  end

  // ALU and PSR next-state: bus load first, then ALU-updated flags override.
  logic [DATA_W-1:0] alu_a, alu_b, b_op, alu_res;
  logic [DATA_W:0]   sum;
  logic              cin;
  logic [3:0]        psr_n;

  always_comb begin
    alu_a   = regs[0];
    alu_b   = bus;
    cin     = psr[0];
    b_op    = (head.alu == 3'd2) ? ~alu_b : alu_b;
    sum     = {1'b0, alu_a} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
    alu_res = alu_r;
    psr_n   = psr;
    if (head.dest[3]) psr_n = {bus[MSB], bus[DATA_W-2], bus[1], bus[0]};
    case (head.alu)
      3'd1, 3'd2: begin
        alu_res  = sum[DATA_W-1:0];
        psr_n[0] = sum[DATA_W];
        psr_n[2] = (alu_a[MSB] == b_op[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      3'd3: alu_res = alu_a & alu_b;
      3'd4: alu_res = alu_a | alu_b;
      3'd5: alu_res = alu_a ^ alu_b;
      3'd6: begin
        alu_res  = {alu_b[DATA_W-2:0], cin};
        psr_n[0] = alu_b[MSB];
      end
      3'd7: begin
        alu_res  = {cin, alu_b[DATA_W-1:1]};
        psr_n[0] = alu_b[0];
      end
      default: alu_res = alu_r;
    endcase
    if (head.alu != 3'd0) begin
      psr_n[1] = (alu_res == '0);
      psr_n[3] = alu_res[MSB];
    end
  end

  logic [2*DATA_W-1:0] pc_n;

  always_comb begin
    pc_n = pc;
    case (head.pc)
      3'd1: pc_n = pc + PC_ONE;
      3'd2: pc_n = pc - PC_ONE;
      3'd3: pc_n = {pc[2*DATA_W-1:DATA_W], bus};
      3'd4: pc_n = {bus, pc[DATA_W-1:0]};
      default: pc_n = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vis_ptr <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      alu_r   <= '0;
      psr     <= '0;
      pc      <= '0;
      dor     <= '0;
      abl     <= '0;
      abh     <= '0;
    end else begin
      vis_ptr <= wr_ptr;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (exec) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (head.wreg)    regs[head.didx] <= bus;
        if (head.dest[0]) dor <= bus;
        if (head.dest[1]) abl <= bus;
        if (head.dest[2]) abh <= bus;
        if (head.alu != 3'd0) alu_r <= alu_res;
        psr <= psr_n;
        pc  <= pc_n;
      end
    end
  end
endmodule

// File: tb/tb_dataflow_engine.sv
module tb_dataflow_engine;
  logic        tb_clk = 1'b0;
  logic        nrst;
  logic [7:0]  dor, abl, abh;
  logic [15:0] pc;
  logic [3:0]  psr;
  logic        busy;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 tb_clk = ~tb_clk;

  dataflow_engine_if #(.DATA_W(8), .NREGS(4)) cif ();

  dataflow_engine #(.DATA_W(8), .NREGS(4), .DEPTH(4)) dut (
    .clk    (tb_clk),
    .nrst   (nrst),
    .cmd_if (cif),
    .dor    (dor),
    .abl    (abl),
    .abh    (abh),
    .pc     (pc),
    .psr    (psr),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one command from a negedge; returns at the negedge after it is accepted.
  task automatic send(input int src, input int sidx, input int wreg, input int didx,
                      input int dest, input int pcop, input int alu);
    int n;
    cif.cmd_src   = src[2:0];
    cif.cmd_sidx  = sidx[1:0];
    cif.cmd_wreg  = wreg[0];
    cif.cmd_didx  = didx[1:0];
    cif.cmd_dest  = dest[3:0];
    cif.cmd_pc    = pcop[2:0];
    cif.cmd_alu   = alu[2:0];
    cif.cmd_valid = 1'b1;
    n = 0;
    while (!cif.cmd_ready && n < 50) begin
      @(negedge tb_clk);
      n++;
    end
    if (n >= 50) begin
      miscompares++;
      $error("FAIL send_timeout: cmd_ready stuck at 0, required 1");
    end
    @(posedge tb_clk);
    @(negedge tb_clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge tb_clk);
      n++;
    end
    if (n >= 100) begin
      miscompares++;
      $error("FAIL drain_timeout: busy stuck at 1, required 0");
    end
  endtask

  task automatic ld(input int idx, input int val);
    cif.data_in = val[7:0];
    send(1, 0, 1, idx, 0, 0, 0);
    drain();
  endtask

  task automatic setpsr(input int val);
    cif.data_in = val[7:0];
    send(1, 0, 0, 0, 8, 0, 0);
    drain();
  endtask

  task automatic alu(input int op, input int val);
    cif.data_in = val[7:0];
    send(1, 0, 0, 0, 0, 0, op);
    drain();
  endtask

  task automatic show_alu();
    send(3, 0, 0, 0, 1, 0, 0);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_src = '0; cif.cmd_sidx = '0; cif.cmd_wreg = 1'b0; cif.cmd_didx = '0;
    cif.cmd_dest = '0; cif.cmd_pc = '0; cif.cmd_alu = '0;
    cif.data_in = '0;
    cif.data_valid = 1'b1;

    // Reset for two edges
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_ready_low", 32'(cif.cmd_ready), 'h0);
    chk("rst_busy", 32'(busy), 'h0);
    nrst = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_pc", 32'(pc), 'h0);
    chk("rst_psr", 32'(psr), 'h0);
    chk("rst_dor", 32'(dor), 'h0);
    chk("rst_abl", 32'(abl), 'h0);
    chk("rst_ready_high", 32'(cif.cmd_ready), 'h1);

    // Register moves, back-to-back: reg1<=data_in, reg0<=reg1, DOR<=reg0
    cif.data_in = 8'hAA;
    send(1, 0, 1, 1, 0, 0, 0);
    send(2, 1, 1, 0, 0, 0, 0);
    send(2, 0, 0, 0, 1, 0, 0);
    chk("mv_dor_edge2", 32'(dor), 'h0);
    @(negedge tb_clk);
    chk("mv_dor_edge3", 32'(dor), 'h0);
    @(negedge tb_clk);
    chk("mv_dor_edge4", 32'(dor), 'hAA);
    chk("mv_busy_done", 32'(busy), 'h0);
    send(2, 1, 0, 0, 2, 0, 0);
    drain();
    chk("mv_reg1_abl", 32'(abl), 'hAA);

    // PC loads, inc/dec wrap
    send(7, 0, 0, 0, 0, 3, 0);
    send(0, 0, 0, 0, 0, 4, 0);
    drain();
    chk("pc_load_00ff", 32'(pc), 'h00FF);
    send(0, 0, 0, 0, 0, 1, 0);
    drain();
    chk("pc_inc_carry", 32'(pc), 'h0100);
    send(0, 0, 0, 0, 0, 3, 0);
    drain();
    chk("pc_pcl_keep_pch", 32'(pc), 'h0100);
    send(0, 0, 0, 0, 0, 4, 0);
    send(0, 0, 0, 0, 0, 2, 0);
    drain();
    chk("pc_dec_wrap", 32'(pc), 'hFFFF);
    cif.data_in = 8'h34;
    send(1, 0, 0, 0, 0, 3, 0);
    drain();
    chk("pc_pcl_34", 32'(pc), 'hFF34);
    cif.data_in = 8'h12;
    send(1, 0, 0, 0, 0, 4, 0);
    drain();
    chk("pc_pch_12", 32'(pc), 'h1234);

    // ALU: 0xFF + 0x01 + 0
    ld(0, 'hFF);
    setpsr(0);
    alu(1, 'h01);
    chk("add_ff_psr", 32'(psr), 'h3);
    show_alu();
    chk("add_ff_res", 32'(dor), 'h00);

    // 0x7F + 0x01 + 0: signed overflow
    ld(0, 'h7F);
    setpsr(0);
    alu(1, 'h01);
    chk("add_ovf_psr", 32'(psr), 'hC);
    show_alu();
    chk("add_ovf_res", 32'(dor), 'h80);

    // ROL 0x80 with C=0
    setpsr(0);
    alu(6, 'h80);
    chk("rol_psr", 32'(psr), 'h3);
    show_alu();
    chk("rol_res", 32'(dor), 'h00);

    // PSR bus load sets C, then SUB 0x7F - 0x01 with C=1 -> 0x7E, C=1
    setpsr('h01);
    chk("psr_load_c", 32'(psr), 'h1);
    alu(2, 'h01);
    chk("sub_psr", 32'(psr), 'h1);
    show_alu();
    chk("sub_res", 32'(dor), 'h7E);

    // AND with PSR load: ALU owns N,Z; V,C from bus 0xC0
    cif.data_in = 8'hC0;
    send(1, 0, 0, 0, 8, 0, 3);
    drain();
    chk("and_psr_merge", 32'(psr), 'h4);
    show_alu();
    chk("and_res", 32'(dor), 'h40);

    // reg0 write and ADD together: ALU sees old reg0 (0x7F)
    cif.data_in = 8'h01;
    send(1, 0, 1, 0, 0, 0, 1);
    drain();
    chk("wr_alu_psr", 32'(psr), 'hC);
    show_alu();
    chk("wr_alu_res", 32'(dor), 'h80);
    send(2, 0, 0, 0, 1, 0, 0);
    drain();
    chk("wr_alu_reg0", 32'(dor), 'h01);

    // ROR 0x02 with C=1
    setpsr('h01);
    alu(7, 'h02);
    chk("ror_psr", 32'(psr), 'h8);
    show_alu();
    chk("ror_res", 32'(dor), 'h81);

    // Stall and backpressure
    cif.data_valid = 1'b0;
    cif.data_in = 8'h5A;
    send(1, 0, 0, 0, 1, 0, 0);
    send(7, 0, 0, 0, 2, 0, 0);
    send(7, 0, 0, 0, 4, 0, 0);
    send(0, 0, 0, 0, 1, 0, 0);
    chk("stall_ready_low", 32'(cif.cmd_ready), 'h0);
    chk("stall_busy", 32'(busy), 'h1);
    repeat (3) @(negedge tb_clk);
    chk("stall_dor_hold", 32'(dor), 'h81);
    chk("stall_abl_hold", 32'(abl), 'hAA);
    chk("stall_ready_hold", 32'(cif.cmd_ready), 'h0);
    cif.data_valid = 1'b1;
    @(negedge tb_clk);
    chk("drain1_dor", 32'(dor), 'h5A);
    chk("drain1_ready", 32'(cif.cmd_ready), 'h1);
    @(negedge tb_clk);
    chk("drain2_abl", 32'(abl), 'hFF);
    @(negedge tb_clk);
    chk("drain3_abh", 32'(abh), 'hFF);
    @(negedge tb_clk);
    chk("drain4_dor", 32'(dor), 'h00);
    chk("drain4_busy", 32'(busy), 'h0);

    // Reset with three commands queued behind a stalled head
    cif.data_valid = 1'b0;
    send(1, 0, 0, 0, 1, 0, 0);
    send(7, 0, 1, 1, 11, 0, 0);
    send(0, 0, 0, 0, 0, 1, 0);
    chk("mid_busy_before", 32'(busy), 'h1);
    nrst = 1'b0;
    @(negedge tb_clk);
    chk("mid_rst_busy", 32'(busy), 'h0);
    chk("mid_rst_ready", 32'(cif.cmd_ready), 'h0);
    chk("mid_rst_pc", 32'(pc), 'h0);
    chk("mid_rst_abh", 32'(abh), 'h0);
    chk("mid_rst_psr", 32'(psr), 'h0);
    nrst = 1'b1;
    cif.data_in = 8'h77;
    cif.data_valid = 1'b1;
    repeat (5) @(negedge tb_clk);
    chk("mid_after_dor", 32'(dor), 'h0);
    chk("mid_after_abl", 32'(abl), 'h0);
    chk("mid_after_pc", 32'(pc), 'h0);
    chk("mid_after_psr", 32'(psr), 'h0);
    chk("mid_after_busy", 32'(busy), 'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dataflow_engine.md
# dataflow_engine

Parametrised successor to the fixed 8-bit internal dataflow. It executes one micro-operation per cycle on a width-configurable register file, a program counter, address and data-out registers, and a registered ALU with status flags. Commands arrive on a valid/ready interface and are buffered in a DEPTH-entry command FIFO. Execution stalls while a command needs external data that is not yet valid. The block sits between the instruction decoder/sequencer and the external bus interface.

## Interface
- DATA_W, 8: datapath width; PC is 2*DATA_W.
- NREGS, 4: general registers; reg[0] is the accumulator; RW = clog2(NREGS).
- DEPTH, 4: command FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full); 0 while nrst low.
- cmd_src  in  3  bus source: 0 zero, 1 data_in, 2 reg[cmd_sidx], 3 alu_r, 4 PCL, 5 PCH, 6 PSR zero-extended, 7 all-ones.
- cmd_sidx  in  RW  source register index.
- cmd_wreg  in  1  load reg[cmd_didx] from bus.
- cmd_didx  in  RW  destination register index.
- cmd_dest  in  4  bit0 DOR, bit1 ABL, bit2 ABH, bit3 PSR, each loaded from bus.
- cmd_pc  in  3  0 hold, 1 inc, 2 dec, 3 PCL<=bus, 4 PCH<=bus, 5–7 hold.
- cmd_alu  in  3  0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ROL, 7 ROR.
- data_in  in  DATA_W  external read data.
- data_valid  in  1  data_in valid this cycle.
- dor, abl, abh  out  DATA_W each  data-out and address registers.
- pc  out  2*DATA_W  program counter {PCH,PCL}.
- psr  out  4  {N,V,Z,C}.
- busy  out  1  FIFO non-empty.

## Operation
- FIFO push when cmd_valid && cmd_ready. Fields are stored packed. There is no pass-through: a full FIFO stays not-ready even if it pops that cycle.
- The head command executes when the FIFO is non-empty and not stalled. A stall occurs when the head has cmd_src==1 && !data_valid. During a stall nothing changes and the head is retained.
- On execution all selected loads occur in the same edge. Every destination samples the same bus value (the pre-edge source).
- PSR bus load: C<=bus[0], Z<=bus[1], V<=bus[DATA_W-2], N<=bus[DATA_W-1].
- ALU: A = reg[0], B = bus; result goes to alu_r. Flags:
  - ADD: A+B+C. SUB: A+~B+C. Both update C (carry-out), V (signed overflow), Z, N.
  - AND/OR/XOR: update Z and N only.
  - ROL: {B[DATA_W-2:0],C}, C<=B[MSB]. ROR: {C,B[DATA_W-1:1]}, C<=B[0]. Both update Z and N.
  - Z = (result==0); N = result MSB.
  - If the ALU and cmd_dest[3] are active together, ALU flags win for the bits the ALU op updates; the remaining PSR bits take the bus value.
- PC wraps modulo 2^(2*DATA_W): inc from all-ones gives 0; dec from 0 gives all-ones. Byte loads leave the other byte unchanged.
- A register write to reg[0] and an ALU op in the same command: the ALU uses the old reg[0].

## Timing
- Reset (nrst low at a rising edge) sets regs, alu_r, psr, pc, dor, abl and abh to 0, empties the FIFO (queued commands discarded), and drives busy=0 and cmd_ready=0. cmd_ready=1 from the first cycle after nrst is released. Reset mid-stream aborts the head without any partial update.
- Latency: a command accepted at edge t reaches the head in cycle t+1 and executes at edge t+2 when not stalled. Its effects are visible on the outputs after that edge.
- Back-to-back dependent commands (register, alu_r, PSR, PC) see the prior command's result with no bubble.
- Throughput is 1 command per cycle. Simultaneous push and pop keeps occupancy constant.
- busy falls in the cycle after the last command executes.

## Test plan
- Reset: drive nrst low 2 cycles, then release → pc=0x0000, psr=0, dor=0, busy=0; cmd_ready=1 the cycle after release.
- Register moves (DATA_W=8): reg1<=data_in 0xAA; reg0<=reg1; DOR<=reg0, all back-to-back → dor=0xAA exactly 4 edges after the first accept; reg contents match.
- PC: load PCL 0xFF, PCH 0x00, inc → 0x0100. Load both bytes to 0, dec → 0xFFFF. Load 0x34 then 0x12 → 0x1234, with the other byte preserved at each step.
- ALU:
  - reg0=0xFF, C=0, ADD data 0x01 → alu_r=0x00, C=1, Z=1, N=0, V=0.
  - reg0=0x7F, ADD 0x01 with C=0 → 0x80, V=1, N=1.
  - ROL of bus 0x80 with C=0 → alu_r=0x00, C=1, Z=1.
- Stall/backpressure: queue a src=data_in command with data_valid=0 and keep pushing → cmd_ready falls after DEPTH accepts, state unchanged. Raise data_valid → commands drain one per cycle and cmd_ready rises the cycle after the first pop.
- Reset mid-stream with 3 commands queued → all discarded, busy=0, all outputs 0, and no queued effect ever appears.
